// File: rtl/rv_if_pkg.sv
// rv_if_pkg: shared fetch-unit types, reset PC default and major RV32 opcodes.
package rv_if_pkg;
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO with registered storage, flush and occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != FULL || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches over req/gnt/rvalid into fetch_fifo for the datapath.
// Define IF_STALL_CNT_EN to add stall_cnt (cycles the consumer was ready but nothing was valid).
module instr_fetch
  import rv_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef IF_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [6:0]  opcode
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, req_pc;
  logic [CW-1:0] count;
  logic [63:0] head;
  logic credit, granted, push, pop;
  assign granted = imem_req && imem_gnt;
  assign credit = (count + CW'(state != REQ)) < CW'(FIFO_DEPTH);
  assign pop = instr_valid && instr_ready;
  assign instr_valid = count != '0;
  assign {instr_pc, instr} = head;
  assign opcode = instr[6:0];
  assign imem_addr = fetch_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= REQ;
    else state <= state_nxt;
  // A redirect with a response still owed must swallow that response in DROP.
  always_comb begin
    state_nxt = state;
    if (pc_src) state_nxt = (state == REQ) ? (granted ? DROP : REQ) : (imem_rvalid ? REQ : DROP);
    else if (state == REQ) state_nxt = granted ? WAIT : REQ;
    else state_nxt = imem_rvalid ? REQ : state;
  end
  always_comb begin
    imem_req = rst_n && state == REQ && credit;
    push = state == WAIT && imem_rvalid && !pc_src;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      if (pc_src) fetch_pc <= {branch_target[31:2], 2'b00};
      else if (granted) fetch_pc <= fetch_pc + 32'd4;
      if (granted) req_pc <= fetch_pc;
    end
`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (instr_ready && !instr_valid && !pc_src && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
`endif
  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata({req_pc, imem_rdata}),
    .pop(pop),
    .flush(pc_src),
    .rdata(head),
    .count(count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench; a queue model of the fetch stream is compared every cycle.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, pc_src = 0, instr_valid, instr_ready = 0;
  logic [31:0] imem_addr, imem_rdata = '0, branch_target = '0, instr, instr_pc;
  logic [6:0] opcode;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int n_cmp = 0, n_bad = 0;
  int lat = 1, hold = 0, run = 0, max_run = 0;
  logic [31:0] glog[$], dlog[$], ilog[$], olog[$];

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_src(pc_src), .branch_target(branch_target), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
`ifdef IF_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .opcode(opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[24:0], 7'h33} ^ {a[31:25], 25'h0};
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hXXXX_XXXX;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_grant();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) break;
    end
    chk("grant_seen", 32'(i < 50), 32'd1);
    @(posedge clk); #1;
  endtask

  // Instruction memory: gnt in the request cycle (after 'hold' refusals), rvalid 'lat' cycles later.
  initial begin : mem
    logic pend;
    logic [31:0] paddr, gaddr;
    int cnt;
    pend = 0; paddr = 0; gaddr = 0; cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        pend = 0; imem_gnt = 0; imem_rvalid = 0;
        continue;
      end
      if (imem_rvalid) pend = 0;
      if (imem_gnt) begin pend = 1; paddr = gaddr; cnt = lat; end
      imem_rvalid = 0;
      if (pend) begin cnt--; imem_rvalid = (cnt == 0); end
      imem_rdata = imem_rvalid ? word(paddr) : 32'hDEAD_BEEF;
      imem_gnt = 0;
      if (imem_req && !pend) begin
        if (hold > 0) hold--;
        else begin imem_gnt = 1; gaddr = imem_addr; end
      end
    end
  end

  initial begin : model
    logic [31:0] q[$];
    logic m_pend, m_drop, p_stall;
    logic [31:0] m_paddr, exp_fetch, m_stall, p_instr, p_pc, pc, w;
    m_pend = 0; m_drop = 0; p_stall = 0; m_paddr = 0; exp_fetch = 0; m_stall = 0; p_instr = 0; p_pc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_op", 32'(opcode), 32'd0);
`ifdef IF_STALL_CNT_EN
        chk("rst_stall", stall_cnt, 32'd0);
`endif
        q.delete(); m_pend = 0; m_drop = 0; exp_fetch = 0; m_stall = 0; p_stall = 0; run = 0;
        continue;
      end
      chk("valid", 32'(instr_valid), 32'(q.size() != 0));
      chk("req", 32'(imem_req), 32'(!m_pend && q.size() < DEPTH));
      if (imem_req) chk("addr", imem_addr, exp_fetch);
      if (p_stall) begin
        chk("hold_instr", instr, p_instr);
        chk("hold_pc", instr_pc, p_pc);
      end
`ifdef IF_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
      if (instr_ready && !instr_valid && !pc_src && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      run = (imem_req && !imem_gnt) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (instr_valid && instr_ready) begin
        chk("pop_avail", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          pc = q.pop_front();
          w = word(pc);
          chk("pop_pc", instr_pc, pc);
          chk("pop_instr", instr, w);
          chk("pop_op", 32'(opcode), 32'(w[6:0]));
        end
        dlog.push_back(instr_pc); ilog.push_back(instr); olog.push_back(32'(opcode));
      end
      if (pc_src) q.delete();
      if (imem_req && imem_gnt) begin
        glog.push_back(imem_addr);
        m_pend = 1; m_paddr = imem_addr; m_drop = pc_src;
      end else if (m_pend && imem_rvalid) begin
        if (!m_drop && !pc_src) q.push_back(m_paddr);
        m_pend = 0;
      end else if (m_pend && pc_src) m_drop = 1;
      if (pc_src) exp_fetch = {branch_target[31:2], 2'b00};
      else if (imem_req && imem_gnt) exp_fetch += 32'd4;
      p_stall = instr_valid && !instr_ready && !pc_src;
      p_instr = instr; p_pc = instr_pc;
    end
  end

  initial begin : main
    int gi, di;
    repeat (3) @(posedge clk); #1;
    rst_n = 1; instr_ready = 1;
    repeat (8) @(posedge clk); #1;
    chk("first_instr", at(ilog, 0), 32'h0050_0093);
    chk("first_pc", at(dlog, 0), 32'h0);
    chk("first_op", at(olog, 0), 32'h13);
    chk("second_pc", at(dlog, 1), 32'h4);
    chk("gaddr0", at(glog, 0), 32'h0);
    chk("gaddr1", at(glog, 1), 32'h4);
    chk("gaddr2", at(glog, 2), 32'h8);
    // consumer stall fills the buffer, then fetching must stop
    instr_ready = 0;
    di = dlog.size();
    repeat (10) @(posedge clk); #1;
    chk("stall_req_off", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_no_pop", 32'(dlog.size()), 32'(di));
    instr_ready = 1;
    repeat (10) @(posedge clk); #1;
    // redirect while waiting for read data
    lat = 3;
    wait_grant();
    pc_src = 1; branch_target = 32'h100;
    @(posedge clk); #1;
    pc_src = 0;
    gi = glog.size(); di = dlog.size();
    repeat (12) @(posedge clk); #1;
    chk("redir_wait_gaddr", at(glog, gi), 32'h100);
    chk("redir_wait_dpc", at(dlog, di), 32'h100);
    // redirect coinciding with rvalid, unaligned target
    lat = 1;
    wait_grant();
    pc_src = 1; branch_target = 32'h203;
    @(posedge clk); #1;
    pc_src = 0;
    gi = glog.size(); di = dlog.size();
    repeat (10) @(posedge clk); #1;
    chk("redir_rv_gaddr", at(glog, gi), 32'h200);
    chk("redir_rv_dpc", at(dlog, di), 32'h200);
    // grant withheld for five request cycles
    max_run = 0; hold = 5;
    repeat (15) @(posedge clk); #1;
    chk("gnt_hold_run", 32'(max_run), 32'd5);
    // reset pulse in the middle of a transaction
    lat = 3;
    wait_grant();
    rst_n = 0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_req", 32'(imem_req), 32'd0);
    repeat (2) @(posedge clk); #1;
    lat = 2; instr_ready = 1;
    gi = glog.size();
    rst_n = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef IF_STALL_CNT_EN
    chk("stall_cnt3", stall_cnt, 32'd3);
`endif
    repeat (10) @(posedge clk); #1;
    chk("rst_gaddr", at(glog, gi), 32'h0);
    repeat (5) @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream neighbour of the control unit in the RV32 core.
- Owns the PC and fetches instruction words from instruction memory over a req/gnt/rvalid bus.
- Buffers fetched words in a small FIFO and presents {instr, pc, opcode} to the datapath/control unit with a valid/ready handshake.
- Accepts a redirect (pc_src + branch_target) from the control unit/datapath and flushes the stale fetch stream.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; arrives 1 or more cycles after gnt
- imem_rdata  in  32  instruction word
- pc_src  in  1  redirect strobe
- branch_target  in  32  redirect address
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  consumer takes head
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- opcode  out  7  instr[6:0]; feeds control unit opcode input

Behaviour:
- Reset (async on rst_n=0):
  - fetch_pc=RESET_PC, FIFO empty, state=REQ.
  - imem_req=0 while in reset; instr_valid=0; instr/instr_pc/opcode=0.
- At most one outstanding request.
- Credit rule: a request is issued only when fifo_count + outstanding < FIFO_DEPTH.
- States:
  - REQ:
    - imem_req=1 when credit is available; imem_addr=fetch_pc.
    - On gnt: fetch_pc+=4 (wraps modulo 2^32), go to WAIT.
    - imem_req and imem_addr hold stable until gnt.
  - WAIT:
    - imem_req=0.
    - On rvalid: push {rdata, pc_of_request} into the FIFO, go to REQ.
  - DROP:
    - imem_req=0.
    - On rvalid: discard rdata, go to REQ.
- FIFO:
  - Pop on instr_valid && instr_ready; push and pop in the same cycle are allowed.
  - Output is registered from the head entry; combinational in/out path is not allowed.
  - First instruction reaches instr_valid no earlier than 1 cycle after rvalid.
- Redirect (pc_src=1 sampled on a clock edge; takes priority over every other event):
  - FIFO cleared; the pop occurring in the same cycle still counts as consumed.
  - fetch_pc = {branch_target[31:2], 2'b00}.
  - If in WAIT, or gnt is seen in that same cycle: go to DROP.
  - rvalid in the same cycle as redirect: data discarded, go to REQ.
  - Otherwise: go to REQ.
  - instr_valid=0 the cycle after redirect.
  - First request to the target is issued the cycle after redirect (from REQ) or after the dropped rvalid (from DROP).
- Consumer stall: instr, instr_pc and opcode stay stable while instr_valid=1 && instr_ready=0.
- Reset mid-transaction: state and FIFO cleared immediately. A late rvalid after reset release while in REQ is ignored; an rvalid is only legal in WAIT/DROP.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0], reset 0.
  - Increments when instr_ready=1 && instr_valid=0 && !pc_src; saturates at 32'hFFFF_FFFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package rv_if_pkg:
  - state enum {REQ, WAIT, DROP}.
  - RESET_PC default.
  - Opcode constants: OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_LOAD=7'b0000011, OP_STORE=7'b0100011.
- Sub-module fetch_fifo (parameterised width/depth, push/pop/flush, count output), instantiated with width 64 for {pc, instr}.

Test Plan:
- Reset release, memory with gnt same cycle and rvalid next cycle, words 0x00500093 at 0x0 and 0x00100113 at 0x4, instr_ready=1 -> instr_valid rises with instr=0x00500093, instr_pc=0x0, opcode=0x13; next instr_pc=0x4; imem_addr sequence 0x0, 0x4, 0x8.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH(2) words fetched, imem_req=0 afterwards, head stable; instr_ready=1 -> drains in order and fetching resumes.
- pc_src=1, branch_target=0x100 while in WAIT -> following rvalid data discarded, FIFO empty, next imem_addr=0x100, next delivered instr_pc=0x100.
- pc_src=1 with branch_target=0x203, same cycle as rvalid -> data dropped, next imem_addr=0x200.
- gnt withheld 5 cycles -> imem_req=1 and imem_addr constant throughout; rst_n pulsed low mid-WAIT -> instr_valid=0 immediately, next imem_addr=RESET_PC.
- IF_STALL_CNT_EN defined, 3 cycles of instr_ready=1 with empty FIFO after reset -> stall_cnt=3; undefined -> compiles without the port.
